// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue: in-order instruction prefetch queue with redirect discard.
// Optional same-cycle response bypass: FETCH_BYPASS_EN.          Rev 1.0
// ============================================================================
`default_nettype none

module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [15:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [15:0] imem_rsp_data,
   input  logic        redirect_i,
   input  logic [15:0] redirect_pc_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [15:0] instr_o,
   output logic [15:0] pc_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int SUM_W = CNT_W + 1;

   logic [15:0]      fetch_pc_q, fetch_pc_d;
   logic [15:0]      rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0] outst_q, outst_d;
   logic [CNT_W-1:0] discard_q, discard_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]      fifo_q [DEPTH];
   logic [31:0]      fifo_d [DEPTH];

   logic             w_empty;
   logic [SUM_W-1:0] w_inflight;
   logic             w_req_fire;
   logic             w_rsp_take;
   logic             w_rsp_keep;
   logic             w_bypass;
   logic             w_push;
   logic             w_pop;

   assign w_empty    = (count_q == '0);
   assign w_inflight = SUM_W'(count_q) + SUM_W'(outst_q);

   // Credit rule: queue entries plus in-flight requests never exceed DEPTH.
   assign imem_req_valid = rst_n && !redirect_i && (w_inflight < SUM_W'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign w_rsp_take = rst_n && imem_rsp_valid && (outst_q != '0);
   assign w_rsp_keep = w_rsp_take && (discard_q == '0) && !redirect_i;

`ifdef FETCH_BYPASS_EN
   assign w_bypass = w_rsp_keep && w_empty;
`else
   assign w_bypass = 1'b0;
`endif

   assign instr_valid_o = rst_n && !redirect_i && (!w_empty || w_bypass);
   assign instr_o = !rst_n  ? 16'h0000 :
                    w_bypass ? imem_rsp_data :
                    w_empty  ? 16'h0000 : fifo_q[rd_ptr_q][15:0];
   assign pc_o    = !rst_n  ? 16'h0000 :
                    w_bypass ? rsp_pc_q :
                    w_empty  ? 16'h0000 : fifo_q[rd_ptr_q][31:16];

   assign w_pop  = instr_valid_o && instr_ready_i && !w_empty;
   assign w_push = w_rsp_keep && !(w_bypass && instr_ready_i);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      outst_d    = outst_q + CNT_W'(w_req_fire) - CNT_W'(w_rsp_take);
      discard_d  = discard_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_d     = fifo_q;

      if (redirect_i) begin
         fetch_pc_d = redirect_pc_i;
         rsp_pc_d   = redirect_pc_i;
         discard_d  = outst_d;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         if (w_req_fire) begin
            fetch_pc_d = fetch_pc_q + 16'd2;
         end
         if (w_rsp_take && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
         end
         // rsp_pc tracks the address of the oldest live (non-discarded) request.
         if (w_rsp_keep) begin
            rsp_pc_d = rsp_pc_q + 16'd2;
         end
         if (w_push) begin
            fifo_d[wr_ptr_q] = {rsp_pc_q, imem_rsp_data};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
         end
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_q     <= fifo_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue: queue-level reference model plus directed fetch scenarios.
// ============================================================================
`default_nettype none

module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clk            = 1'b0;
   logic        rst_n          = 1'b0;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [15:0] imem_rsp_data  = 16'h0000;
   logic        redirect_i     = 1'b0;
   logic [15:0] redirect_pc_i  = 16'h0000;
   logic        instr_ready_i  = 1'b0;
   logic        imem_req_valid;
   logic [15:0] imem_req_addr;
   logic        instr_valid_o;
   logic [15:0] instr_o;
   logic [15:0] pc_o;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_i     (redirect_i),
      .redirect_pc_i  (redirect_pc_i),
      .instr_valid_o  (instr_valid_o),
      .instr_ready_i  (instr_ready_i),
      .instr_o        (instr_o),
      .pc_o           (pc_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Instruction memory: in-order, one-cycle latency, data = addr ^ A5A5.
   logic [15:0] mem_q[$];
   bit          mem_hold = 1'b0;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && imem_req_valid === 1'b1 && imem_req_ready === 1'b1)
         mem_q.push_back(imem_req_addr);
   end

   always @(posedge clk) begin
      #2;
      if (!mem_hold && mem_q.size() > 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_q.pop_front() ^ 16'hA5A5;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 16'h0000;
      end
   end

   // Reference model: outstanding request list (with stale marks) and the
   // list of instructions waiting to be delivered.
   typedef struct { bit stale; bit [15:0] addr; } pend_t;
   typedef struct { bit [15:0] pc; bit [15:0] ins; } ent_t;

   pend_t     m_pend[$];
   ent_t      m_fifo[$];
   bit [15:0] m_fetch_pc = RESET_PC;
   bit [15:0] got_pc[$];
   bit [15:0] got_ins[$];
   bit        m_live, m_byp, m_valid, m_reqv, m_cons;
   ent_t      m_head;
   pend_t     m_p;

   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         chk("rst_req_valid", 16'(imem_req_valid), 16'h0);
         chk("rst_instr_valid", 16'(instr_valid_o), 16'h0);
         chk("rst_instr", instr_o, 16'h0);
         chk("rst_pc", pc_o, 16'h0);
         m_pend.delete();
         m_fifo.delete();
         m_fetch_pc = RESET_PC;
      end else begin
         m_live = imem_rsp_valid && (m_pend.size() > 0);
         m_byp  = 1'b0;
`ifdef FETCH_BYPASS_EN
         m_byp = m_live && !redirect_i && (m_fifo.size() == 0) && !m_pend[0].stale;
`endif
         m_reqv  = !redirect_i && ((m_fifo.size() + m_pend.size()) < DEPTH);
         m_valid = !redirect_i && ((m_fifo.size() > 0) || m_byp);
         chk("req_valid", 16'(imem_req_valid), 16'(m_reqv));
         chk("req_addr", imem_req_addr, m_fetch_pc);
         chk("instr_valid", 16'(instr_valid_o), 16'(m_valid));
         if (m_valid) begin
            if (m_byp) m_head = '{pc: m_pend[0].addr, ins: imem_rsp_data};
            else       m_head = m_fifo[0];
            chk("pc_o", pc_o, m_head.pc);
            chk("instr_o", instr_o, m_head.ins);
         end
         if (redirect_i) begin
            m_fifo.delete();
            if (m_live) void'(m_pend.pop_front());
            foreach (m_pend[i]) m_pend[i].stale = 1'b1;
            m_fetch_pc = redirect_pc_i;
         end else begin
            m_cons = 1'b0;
            if (m_valid && instr_ready_i) begin
               got_pc.push_back(m_head.pc);
               got_ins.push_back(m_head.ins);
               if (m_byp) m_cons = 1'b1;
               else       void'(m_fifo.pop_front());
            end
            if (m_live) begin
               m_p = m_pend.pop_front();
               if (!m_p.stale && !m_cons) m_fifo.push_back('{pc: m_p.addr, ins: imem_rsp_data});
            end
            if (m_reqv && imem_req_ready) begin
               m_pend.push_back('{stale: 1'b0, addr: m_fetch_pc});
               m_fetch_pc = m_fetch_pc + 16'd2;
            end
         end
      end
   end

   function automatic logic [15:0] pc_at(input int i);
      if (i < got_pc.size()) return got_pc[i];
      return 16'hDEAD;
   endfunction

   function automatic logic [15:0] ins_at(input int i);
      if (i < got_ins.size()) return got_ins[i];
      return 16'hDEAD;
   endfunction

   task automatic wait_deliv(input int idx, input int budget);
      int k = 0;
      while (got_pc.size() <= idx && k < budget) begin
         tick();
         k++;
      end
   endtask

   int n0;
   int streak;
   int breaks;

   initial begin
      repeat (3) tick();
      @(negedge clk); #1;
      chk("reset_req_valid", 16'(imem_req_valid), 16'h0);
      chk("reset_instr_valid", 16'(instr_valid_o), 16'h0);
      chk("reset_instr_o", instr_o, 16'h0);
      chk("reset_pc_o", pc_o, 16'h0);

      // Reset release with a ready memory and IF/DE stage.
      tick();
      rst_n = 1'b1; imem_req_ready = 1'b1; instr_ready_i = 1'b1;
      @(negedge clk); #1;
      chk("first_req_valid", 16'(imem_req_valid), 16'h1);
      chk("first_req_addr", imem_req_addr, 16'h0000);
      tick();
      @(negedge clk); #1;
`ifdef FETCH_BYPASS_EN
      chk("bypass_valid", 16'(instr_valid_o), 16'h1);
      chk("bypass_instr", instr_o, 16'hA5A5);
`else
      chk("nobypass_valid", 16'(instr_valid_o), 16'h0);
`endif
      tick();
      @(negedge clk); #1;
`ifdef FETCH_BYPASS_EN
      chk("bypass2_pc", pc_o, 16'h0002);
      chk("bypass2_instr", instr_o, 16'hA5A7);
`else
      chk("late_valid", 16'(instr_valid_o), 16'h1);
      chk("late_instr", instr_o, 16'hA5A5);
      chk("late_pc", pc_o, 16'h0000);
`endif
      repeat (6) tick();
      chk("seq_pc0", pc_at(0), 16'h0000);
      chk("seq_pc1", pc_at(1), 16'h0002);
      chk("seq_pc2", pc_at(2), 16'h0004);
      chk("seq_ins0", ins_at(0), 16'hA5A5);
      chk("seq_ins1", ins_at(1), 16'hA5A7);
      chk("seq_ins2", ins_at(2), 16'hA5A1);

      // Stall the IF/DE stage for 10 cycles until the queue fills.
      instr_ready_i = 1'b0;
      repeat (9) tick();
      @(negedge clk); #1;
      chk("stall_req_valid", 16'(imem_req_valid), 16'h0);
      chk("stall_instr_valid", 16'(instr_valid_o), 16'h1);
      n0 = got_pc.size();
      tick();
      instr_ready_i = 1'b1;
      streak = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (instr_valid_o === 1'b1) streak++;
         tick();
      end
      chk("drain_valid_cycles", 16'(streak), 16'd4);
      chk("drain_count", 16'(got_pc.size() - n0), 16'd4);
      breaks = 0;
      for (int i = 1; i < got_pc.size(); i++)
         if (got_pc[i] != got_pc[i-1] + 16'd2) breaks++;
      chk("no_gap", 16'(breaks), 16'd0);

      // Redirect with exactly two requests outstanding.
      imem_req_ready = 1'b0;
      repeat (3) tick();
      mem_hold = 1'b1; imem_req_ready = 1'b1;
      repeat (2) tick();
      redirect_i = 1'b1; redirect_pc_i = 16'h0100;
      tick();
      redirect_i = 1'b0; mem_hold = 1'b0;
      n0 = got_pc.size();
      wait_deliv(n0, 20);
      chk("redirect_pc", pc_at(n0), 16'h0100);
      chk("redirect_instr", ins_at(n0), 16'hA4A5);

      // Fetch address wrap at the top of the address space.
      redirect_i = 1'b1; redirect_pc_i = 16'hFFFE;
      n0 = got_pc.size();
      tick();
      redirect_i = 1'b0;
      @(negedge clk); #1;
      chk("wrap_addr_hi", imem_req_addr, 16'hFFFE);
      chk("wrap_req_valid", 16'(imem_req_valid), 16'h1);
      tick();
      @(negedge clk); #1;
      chk("wrap_addr_lo", imem_req_addr, 16'h0000);
      wait_deliv(n0 + 1, 20);
      chk("wrap_deliv_hi", pc_at(n0), 16'hFFFE);
      chk("wrap_deliv_lo", pc_at(n0 + 1), 16'h0000);

      // Reset with three requests in flight; a stale response follows.
      imem_req_ready = 1'b0;
      repeat (3) tick();
      mem_hold = 1'b1; imem_req_ready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b0; imem_req_ready = 1'b0; mem_hold = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("post_rst_req_valid", 16'(imem_req_valid), 16'h1);
      chk("post_rst_req_addr", imem_req_addr, 16'h0000);
      chk("stale_no_bypass", 16'(instr_valid_o), 16'h0);
      tick();
      @(negedge clk); #1;
      chk("stale_ignored", 16'(instr_valid_o), 16'h0);
      tick();
      imem_req_ready = 1'b1;
      n0 = got_pc.size();
      wait_deliv(n0, 20);
      chk("post_rst_pc", pc_at(n0), 16'h0000);
      chk("post_rst_instr", ins_at(n0), 16'hA5A5);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
